// File: rtl/data_sram_responder_pkg.sv
// -----------------------------------------------------------------------------
// data_sram_responder_pkg
//   Shared constants for the data SRAM responder: FSM state encodings, the
//   wait-state counter width and the stall request levels seen by the
//   pipeline stall controller.
// -----------------------------------------------------------------------------
package data_sram_responder_pkg;

   // Encodings match the legacy DSRAM_IDLE/DSRAM_WAIT values.
   typedef enum logic [0:0] {
      DSRAM_IDLE = 1'b0,
      DSRAM_WAIT = 1'b1
   } dsram_state_e;

   localparam int unsigned DSRAM_WAIT_W = 4;

   // Stall request levels driven onto stallreq_mem.
   localparam logic Stop   = 1'b1;
   localparam logic NoStop = 1'b0;

   // Counter load value on entry to WAIT: the request cycle itself is the
   // first stalled cycle, so WAIT only has to cover the remaining N-1.
   function automatic logic [DSRAM_WAIT_W-1:0] wait_load(input int unsigned n);
      logic [DSRAM_WAIT_W-1:0] v;
      v = '0;
      if (n != 0) begin
         v = DSRAM_WAIT_W'(n - 1);
      end
      return v;
   endfunction

endpackage

// File: rtl/sram_byte_array.sv
// -----------------------------------------------------------------------------
// sram_byte_array
//   2^ADDR_WIDTH x 32-bit storage with per-byte write enables and a
//   registered read port. Contents are never cleared; only the read data
//   register is reset.
//
// Ports
//   clk       core clock
//   rst       asynchronous active-high reset (read register only)
//   commit_i  access commits at this rising edge
//   wen_i     byte write enables; all-zero with commit_i means read
//   idx_i     word index
//   wdata_i   write data, lane i = bits 8i+7:8i
//   rdata_o   registered read data, updated only by a read commit
// -----------------------------------------------------------------------------
module sram_byte_array #(
   parameter int unsigned ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  commit_i,
   input  logic [3:0]            wen_i,
   input  logic [ADDR_WIDTH-1:0] idx_i,
   input  logic [31:0]           wdata_i,
   output logic [31:0]           rdata_o
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   logic [31:0] mem_q [DEPTH];
   logic [31:0] rdata_q;

   always_ff @(posedge clk) begin
      if (commit_i) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (wen_i[i]) begin
               mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_q <= '0;
      end else if (commit_i && (wen_i == 4'b0000)) begin
         rdata_q <= mem_q[idx_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/data_sram_responder.sv
// -----------------------------------------------------------------------------
// data_sram_responder
//   Responder end of the data SRAM interface. Accepts EX-stage requests and
//   returns registered read data to MEM one cycle after commit. With
//   WAIT_CYCLES > 0 each access is held for that many cycles with
//   stallreq_mem raised before it commits.
//
// Ports
//   clk              core clock, rising edge
//   rst              asynchronous active-high reset
//   data_sram_en     access request this cycle
//   data_sram_wen    byte write enables (0000 = read)
//   data_sram_addr   byte address; word index = addr[ADDR_WIDTH+1:2]
//   data_sram_wdata  write data
//   data_sram_rdata  registered read data
//   stallreq_mem     pipeline freeze request while wait states run
// -----------------------------------------------------------------------------
module data_sram_responder
   import data_sram_responder_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = 10,
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        data_sram_en,
   input  logic [3:0]  data_sram_wen,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   output logic        stallreq_mem
);

   localparam logic [DSRAM_WAIT_W-1:0] WaitInit = wait_load(WAIT_CYCLES);

   dsram_state_e             state_q, state_d;
   logic [DSRAM_WAIT_W-1:0]  cnt_q, cnt_d;
   logic                     stall_raw;
   logic                     commit_raw;
   logic                     commit;
   logic [ADDR_WIDTH-1:0]    word_idx;

   // Byte offset and bits above the array size are deliberately ignored, so
   // addresses alias modulo the array size.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{data_sram_addr[31:ADDR_WIDTH+2], data_sram_addr[1:0]};

   assign word_idx = data_sram_addr[ADDR_WIDTH+1:2];

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      stall_raw  = NoStop;
      commit_raw = 1'b0;

      if (WAIT_CYCLES == 0) begin
         commit_raw = data_sram_en;
      end else begin
         case (state_q)
            DSRAM_IDLE: begin
               if (data_sram_en) begin
                  stall_raw = Stop;
                  state_d   = DSRAM_WAIT;
                  cnt_d     = WaitInit;
               end
            end
            DSRAM_WAIT: begin
               if (!data_sram_en) begin
                  // Request withdrawn (flush): drop it without touching the array.
                  state_d = DSRAM_IDLE;
                  cnt_d   = '0;
               end else if (cnt_q != '0) begin
                  stall_raw = Stop;
                  cnt_d     = cnt_q - 1'b1;
               end else begin
                  commit_raw = 1'b1;
                  state_d    = DSRAM_IDLE;
               end
            end
            default: begin
               state_d = DSRAM_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= DSRAM_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Reset masks both outputs of the FSM immediately: the stall request drops
   // without waiting for an edge, and an edge during reset writes nothing.
   assign commit       = commit_raw & ~rst;
   assign stallreq_mem = stall_raw & ~rst;

   sram_byte_array #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_array (
      .clk      (clk),
      .rst      (rst),
      .commit_i (commit),
      .wen_i    (data_sram_wen),
      .idx_i    (word_idx),
      .wdata_i  (data_sram_wdata),
      .rdata_o  (data_sram_rdata)
   );

endmodule
